vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between two requesters: the scan-out fetch path (video) and the host bus (cpu).
- The RAM has 1-cycle registered read latency and a synchronous write.
- Video normally has priority. An aging counter guarantees the cpu a slot after MAX_WAIT consecutive lost cycles.
- Sits between the video timing/fetch logic, the bus interface and the RAM instance.

---
 rtl/vram_arbiter.sv | 102 ++++++++++
 tb/tb_vram_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Shares one single-port synchronous video RAM between the video
//            scan-out fetch path and the host cpu bus. Video has priority.
//            An aging counter forces a cpu grant after MAX_WAIT lost cycles.
//            A one-deep read tag routes the 1-cycle read data to its owner.
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // video fetch port (read only)
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_ack,
  output logic                  vid_valid,
  output logic [DATA_WIDTH-1:0] vid_data,
  // host cpu port
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  output logic                  cpu_ack,
  output logic                  cpu_valid,
  output logic [DATA_WIDTH-1:0] cpu_dout,
  // RAM side
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_wen,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  // Saturation point of the aging counter, held in the counter's own width.
  localparam logic [7:0] C_MAX_WAIT = 8'(MAX_WAIT);

  // Owner of the read whose data appears on ram_dout this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  owner_t     rd_owner_q, rd_owner_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic       starve;
  logic       grant_cpu;
  logic       grant_vid;

  // Arbitration: video wins unless the cpu has lost MAX_WAIT cycles in a row.
  always_comb begin
    starve    = (wait_cnt_q == C_MAX_WAIT);
    grant_cpu = cpu_req & (~vid_req | starve);
    grant_vid = vid_req & ~grant_cpu;
  end

  // Handshake, RAM drive and read-data routing; everything visible is
  // forced quiet while reset is high so no stray write or valid escapes.
  always_comb begin
    vid_ack   = grant_vid & ~reset;
    cpu_ack   = grant_cpu & ~reset;
    ram_addr  = grant_cpu ? cpu_addr : vid_addr;
    ram_din   = cpu_din;
    ram_wen   = grant_cpu & cpu_we & ~reset;
    vid_valid = (rd_owner_q == OWN_VID) & ~reset;
    cpu_valid = (rd_owner_q == OWN_CPU) & ~reset;
    vid_data  = ram_dout;
    cpu_dout  = ram_dout;
  end

  // Next read tag and next aging count.
  always_comb begin
    rd_owner_d = OWN_NONE;
    wait_cnt_d = 8'd0;
    if (grant_cpu && !cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (grant_vid) begin
      rd_owner_d = OWN_VID;
    end
    if (cpu_req && !grant_cpu) begin
      wait_cnt_d = starve ? C_MAX_WAIT : (wait_cnt_q + 8'd1);
    end
  end

  // State registers; reset clears the tag so an in-flight read is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_q <= OWN_NONE;
      wait_cnt_q <= 8'd0;
    end else begin
      rd_owner_q <= rd_owner_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Self-checking bench for vram_arbiter with a behavioural RAM and
//            a reference model of grants, read returns and cpu aging.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic          cpu_ack;
  logic          cpu_valid;
  logic [DW-1:0] cpu_dout;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_wen;
  logic [DW-1:0] ram_dout;

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_valid(vid_valid), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_valid(cpu_valid),
    .cpu_dout(cpu_dout),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_wen(ram_wen),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM: registered read, synchronous write.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            pend;       // 0 none, 1 video read returning, 2 cpu read returning
  logic [DW-1:0] pend_data;
  int            losses;     // consecutive cycles the cpu asked and lost
  logic          last_cg, last_vg;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic do_cycle(input logic rst, input logic vr, input logic [AW-1:0] va,
                          input logic cr, input logic cw, input logic [AW-1:0] ca,
                          input logic [DW-1:0] cd);
    logic cg, vg;
    reset = rst; vid_req = vr; vid_addr = va;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_din = cd;
    #1;
    cg = cr && (!vr || losses == MW) && !rst;
    vg = vr && !cg && !rst;
    check("vid_ack", {15'd0, vid_ack}, {15'd0, vg});
    check("cpu_ack", {15'd0, cpu_ack}, {15'd0, cg});
    check("ram_wen", {15'd0, ram_wen}, {15'd0, cg && cw});
    check("vid_valid", {15'd0, vid_valid}, {15'd0, (pend == 1) && !rst});
    check("cpu_valid", {15'd0, cpu_valid}, {15'd0, (pend == 2) && !rst});
    if (pend == 1 && !rst) check("vid_data", {8'd0, vid_data}, {8'd0, pend_data});
    if (pend == 2 && !rst) check("cpu_dout", {8'd0, cpu_dout}, {8'd0, pend_data});
    if (cg) begin
      check("ram_addr", {4'd0, ram_addr}, {4'd0, ca});
      check("ram_din", {8'd0, ram_din}, {8'd0, cd});
    end else if (vg) begin
      check("ram_addr", {4'd0, ram_addr}, {4'd0, va});
    end
    last_cg = cg; last_vg = vg;
    @(posedge clk);
    if (rst) begin
      pend = 0; losses = 0;
    end else begin
      pend = 0;
      if (cg && cw) ref_mem[ca] = cd;
      else if (cg) begin pend = 2; pend_data = ref_mem[ca]; end
      else if (vg) begin pend = 1; pend_data = ref_mem[va]; end
      if (cr && !cg) losses = (losses >= MW) ? MW : losses + 1;
      else losses = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic          vr_on, cr_on, cwr;
    logic [AW-1:0] vad, cad;
    logic [DW-1:0] cdat;
    int            cnt_c;
    pend = 0; losses = 0; pend_data = '0; last_cg = 0; last_vg = 0;
    reset = 1; vid_req = 0; vid_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    @(negedge clk);

    // Reset state
    do_cycle(1, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 1, 5, 1, 1, 5, 8'h11);

    // Preload addresses 0..63 through cpu writes
    for (int i = 0; i < 64; i++) do_cycle(0, 0, 0, 1, 1, AW'(i), DW'(i * 7 + 3));
    do_cycle(0, 0, 0, 1, 1, 12'h010, 8'hA5);
    do_cycle(0, 0, 0, 0, 0, 0, 0);

    // Cpu read alone
    do_cycle(0, 0, 0, 1, 0, 12'h010, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0);

    // Cpu write then video read of the same address on the next cycle
    do_cycle(0, 0, 0, 1, 1, 12'h123, 8'h3C);
    do_cycle(0, 1, 12'h123, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0);

    // Contention aging: both held high, 4:1 pattern
    cnt_c = 0;
    for (int i = 0; i < 15; i++) begin
      do_cycle(0, 1, 12'h006, 1, 0, 12'h005, 0);
      if (last_cg) cnt_c++;
    end
    check("aging_cpu_grants", 16'(cnt_c), 16'd3);
    do_cycle(0, 0, 0, 0, 0, 0, 0);

    // Streaming video 0..15
    for (int i = 0; i < 16; i++) do_cycle(0, 1, AW'(i), 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0);

    // Reset mid-read, with both requesting (cpu write) during reset
    do_cycle(0, 1, 12'h003, 0, 0, 0, 0);
    do_cycle(1, 1, 12'h004, 1, 1, 12'h007, 8'hEE);
    do_cycle(1, 1, 12'h004, 1, 1, 12'h007, 8'hEE);
    for (int i = 0; i < 6; i++) do_cycle(0, 1, 12'h004, 1, 0, 12'h007, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0);

    // Cpu drops its request while losing; aging restarts from zero
    do_cycle(0, 1, 12'h008, 1, 0, 12'h009, 0);
    do_cycle(0, 1, 12'h008, 1, 0, 12'h009, 0);
    do_cycle(0, 1, 12'h008, 0, 0, 0, 0);
    cnt_c = 0;
    for (int i = 0; i < 5; i++) begin
      do_cycle(0, 1, 12'h008, 1, 0, 12'h009, 0);
      if (last_cg) cnt_c = i + 1;
    end
    check("drop_wait_full", 16'(cnt_c), 16'd5);
    do_cycle(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with the hold-until-ack requester rule
    vr_on = 0; cr_on = 0; vad = '0; cad = '0; cwr = 0; cdat = '0;
    for (int n = 0; n < 400; n++) begin
      if (!vr_on && $urandom_range(0, 3) != 0) begin
        vr_on = 1; vad = AW'($urandom_range(0, 63));
      end
      if (!cr_on && $urandom_range(0, 2) == 0) begin
        cr_on = 1; cad = AW'($urandom_range(0, 63));
        cwr = $urandom_range(0, 1) == 1; cdat = DW'($urandom);
      end
      do_cycle((n % 97) == 96, vr_on, vad, cr_on, cwr, cad, cdat);
      if (last_vg) begin
        vr_on = $urandom_range(0, 1) == 1;
        vad = AW'($urandom_range(0, 63));
      end
      if (last_cg) begin
        cr_on = $urandom_range(0, 1) == 1;
        cad = AW'($urandom_range(0, 63));
        cwr = $urandom_range(0, 1) == 1; cdat = DW'($urandom);
      end
    end
    do_cycle(0, 0, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
